// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32 definitions used by the machine-mode CSR file.
//   - CSR addresses for the implemented machine-mode registers
//   - csr_op_e request encoding
//   - mstatus bit positions, trap cause codes, default trap vector
package rv32_pkg;

    localparam logic [31:0] EXCEPTION_HANDLER_ADDR = 32'h0000_0100;

    typedef enum logic [1:0] {
        CSR_WRITE = 2'd0,
        CSR_SET   = 2'd1,
        CSR_CLEAR = 2'd2,
        CSR_READ  = 2'd3
    } csr_op_e;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;

    localparam logic [31:0] CAUSE_INSN_MISALIGNED = 32'd0;
    localparam logic [31:0] CAUSE_ILLEGAL_INSN    = 32'd2;
    localparam logic [31:0] CAUSE_BREAKPOINT      = 32'd3;
    localparam logic [31:0] CAUSE_LOAD_MISALIGNED = 32'd4;
    localparam logic [31:0] CAUSE_STORE_MISALIGN  = 32'd6;
    localparam logic [31:0] CAUSE_ECALL_M         = 32'd11;

endpackage

// File: rtl/csr_counter64.sv
// csr_counter64: 64-bit free-running counter with software-writable halves.
//   clk_i, rst_i  clock / synchronous active-high reset (clears count)
//   inc_i         count up by one this cycle
//   we_lo_i       replace bits [31:0] with wdata_i (upper half holds)
//   we_hi_i       replace bits [63:32] with wdata_i (lower half holds)
//   wdata_i       write data for either half
//   count_o       current 64-bit count
// A write to either half takes the place of the increment for that cycle,
// so no carry is propagated on a write edge.
module csr_counter64 (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        inc_i,
    input  logic        we_lo_i,
    input  logic        we_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] count_o
);

    logic [63:0] cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i)        cnt          <= '0;
        else if (we_lo_i) cnt[31:0]    <= wdata_i;
        else if (we_hi_i) cnt[63:32]   <= wdata_i;
        else if (inc_i)   cnt          <= cnt + 64'd1;
    end

    assign count_o = cnt;

endmodule

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR register file.
//   CSR port   : csr_addr_i, csr_wdata_i, csr_op_i, csr_we_i -> csr_rdata_o (old value,
//                combinational), csr_illegal_o (unmapped or write to read-only)
//   Trap port  : trap_valid_i, trap_cause_i, trap_pc_i, trap_tval_i, mret_i
//   Counters   : retire_i bumps minstret; mcycle counts every cycle
//   PC select  : mtvec_o, mepc_o, mie_o
// Same-edge priority is trap > mret > software write; a software write that
// collides with a trap or mret is dropped only for the trap-owned registers.
module csr_file
    import rv32_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = EXCEPTION_HANDLER_ADDR,
    parameter logic [31:0] HART_ID     = 32'd0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [11:0] csr_addr_i,
    input  logic [31:0] csr_wdata_i,
    input  logic [1:0]  csr_op_i,
    input  logic        csr_we_i,
    output logic [31:0] csr_rdata_o,
    output logic        csr_illegal_o,
    input  logic        trap_valid_i,
    input  logic [31:0] trap_cause_i,
    input  logic [31:0] trap_pc_i,
    input  logic [31:0] trap_tval_i,
    input  logic        mret_i,
    input  logic        retire_i,
    output logic [31:0] mtvec_o,
    output logic [31:0] mepc_o,
    output logic        mie_o
);

    logic        mie, mpie;
    logic [31:0] mtvec, mepc, mcause, mtval, mscratch;
    logic [63:0] mcycle, minstret;
    logic [31:0] mstatus_rd;
    logic        mapped, wr_en, trap_owned_ok;
    logic [31:0] wval;

    // mstatus: only MIE/MPIE are stored; MPP is hardwired to M-mode.
    always_comb begin
        mstatus_rd                   = '0;
        mstatus_rd[12:11]            = 2'b11;
        mstatus_rd[MSTATUS_MPIE_BIT] = mpie;
        mstatus_rd[MSTATUS_MIE_BIT]  = mie;
    end

    always_comb begin
        mapped      = 1'b1;
        csr_rdata_o = '0;
        case (csr_addr_i)
            CSR_MSTATUS:   csr_rdata_o = mstatus_rd;
            CSR_MTVEC:     csr_rdata_o = mtvec;
            CSR_MSCRATCH:  csr_rdata_o = mscratch;
            CSR_MEPC:      csr_rdata_o = mepc;
            CSR_MCAUSE:    csr_rdata_o = mcause;
            CSR_MTVAL:     csr_rdata_o = mtval;
            CSR_MCYCLE:    csr_rdata_o = mcycle[31:0];
            CSR_MCYCLEH:   csr_rdata_o = mcycle[63:32];
            CSR_MINSTRET:  csr_rdata_o = minstret[31:0];
            CSR_MINSTRETH: csr_rdata_o = minstret[63:32];
            CSR_MHARTID:   csr_rdata_o = HART_ID;
            CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: csr_rdata_o = '0;
            default:       mapped = 1'b0;
        endcase
    end

    assign csr_illegal_o = ~mapped ||
                           (csr_addr_i[11:10] == 2'b11 && csr_op_i != CSR_READ);

    always_comb begin
        case (csr_op_e'(csr_op_i))
            CSR_WRITE: wval = csr_wdata_i;
            CSR_SET:   wval = csr_rdata_o | csr_wdata_i;
            CSR_CLEAR: wval = csr_rdata_o & ~csr_wdata_i;
            default:   wval = csr_rdata_o;
        endcase
    end

    assign wr_en         = csr_we_i && !csr_illegal_o && csr_op_i != CSR_READ;
    assign trap_owned_ok = !trap_valid_i && !mret_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mie      <= 1'b0;
            mpie     <= 1'b0;
            mtvec    <= MTVEC_RESET & ~32'd3;
            mepc     <= '0;
            mcause   <= '0;
            mtval    <= '0;
            mscratch <= '0;
        end else begin
            if (wr_en) begin
                case (csr_addr_i)
                    CSR_MSCRATCH: mscratch <= wval;
                    CSR_MTVEC:    mtvec    <= wval & ~32'd3;
                    CSR_MEPC:     if (trap_owned_ok) mepc   <= wval & ~32'd3;
                    CSR_MCAUSE:   if (trap_owned_ok) mcause <= wval;
                    CSR_MTVAL:    if (trap_owned_ok) mtval  <= wval;
                    CSR_MSTATUS: if (trap_owned_ok) begin
                        mie  <= wval[MSTATUS_MIE_BIT];
                        mpie <= wval[MSTATUS_MPIE_BIT];
                    end
                    default: ;
                endcase
            end
            if (trap_valid_i) begin
                mepc   <= trap_pc_i & ~32'd3;
                mcause <= trap_cause_i;
                mtval  <= trap_tval_i;
                mpie   <= mie;
                mie    <= 1'b0;
            end else if (mret_i) begin
                mie  <= mpie;
                mpie <= 1'b1;
            end
        end
    end

    csr_counter64 u_mcycle (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (1'b1),
        .we_lo_i (wr_en && csr_addr_i == CSR_MCYCLE),
        .we_hi_i (wr_en && csr_addr_i == CSR_MCYCLEH),
        .wdata_i (wval),
        .count_o (mcycle)
    );

    csr_counter64 u_minstret (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (retire_i),
        .we_lo_i (wr_en && csr_addr_i == CSR_MINSTRET),
        .we_hi_i (wr_en && csr_addr_i == CSR_MINSTRETH),
        .wdata_i (wval),
        .count_o (minstret)
    );

    assign mtvec_o = mtvec & ~32'd3;
    assign mepc_o  = mepc;
    assign mie_o   = mie;

endmodule

// File: tb/tb_csr_file.sv
module tb_csr_file;
    import rv32_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [11:0] csr_addr_i = CSR_MCYCLE;
    logic [31:0] csr_wdata_i = '0;
    logic [1:0]  csr_op_i = CSR_READ;
    logic        csr_we_i = 1'b0;
    logic [31:0] csr_rdata_o;
    logic        csr_illegal_o;
    logic        trap_valid_i = 1'b0;
    logic [31:0] trap_cause_i = '0, trap_pc_i = '0, trap_tval_i = '0;
    logic        mret_i = 1'b0, retire_i = 1'b0;
    logic [31:0] mtvec_o, mepc_o;
    logic        mie_o;

    always #5 clk = ~clk;

    csr_file #(.MTVEC_RESET(32'h0000_0100), .HART_ID(32'd0)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i), .csr_op_i(csr_op_i),
        .csr_we_i(csr_we_i), .csr_rdata_o(csr_rdata_o), .csr_illegal_o(csr_illegal_o),
        .trap_valid_i(trap_valid_i), .trap_cause_i(trap_cause_i), .trap_pc_i(trap_pc_i),
        .trap_tval_i(trap_tval_i), .mret_i(mret_i), .retire_i(retire_i),
        .mtvec_o(mtvec_o), .mepc_o(mepc_o), .mie_o(mie_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_valid = 1'b0;
    logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause, m_mtval, m_mscratch;
    logic [63:0] m_mcycle, m_minstret;

    function automatic logic m_mapped(input logic [11:0] a);
        return a inside {CSR_MSTATUS, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
                         CSR_MTVAL, CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH,
                         CSR_MHARTID, CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID};
    endfunction

    function automatic logic m_ill(input logic [11:0] a, input logic [1:0] op);
        return !m_mapped(a) || (a >= 12'hC00 && op != CSR_READ);
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            CSR_MSTATUS:   return m_mstatus;
            CSR_MTVEC:     return m_mtvec;
            CSR_MSCRATCH:  return m_mscratch;
            CSR_MEPC:      return m_mepc;
            CSR_MCAUSE:    return m_mcause;
            CSR_MTVAL:     return m_mtval;
            CSR_MCYCLE:    return m_mcycle[31:0];
            CSR_MCYCLEH:   return m_mcycle[63:32];
            CSR_MINSTRET:  return m_minstret[31:0];
            CSR_MINSTRETH: return m_minstret[63:32];
            default:       return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin : model
        logic [31:0] old, nv;
        logic        w, owned;
        if (rst_i) begin
            m_valid    <= 1'b1;
            m_mstatus  <= 32'h1800;
            m_mtvec    <= 32'h100;
            m_mepc     <= 0; m_mcause <= 0; m_mtval <= 0; m_mscratch <= 0;
            m_mcycle   <= 0; m_minstret <= 0;
        end else if (m_valid) begin
            old = m_read(csr_addr_i);
            case (csr_op_i)
                CSR_WRITE: nv = csr_wdata_i;
                CSR_SET:   nv = old | csr_wdata_i;
                CSR_CLEAR: nv = old & ~csr_wdata_i;
                default:   nv = old;
            endcase
            w     = csr_we_i && csr_op_i != CSR_READ && !m_ill(csr_addr_i, csr_op_i);
            owned = !trap_valid_i && !mret_i;

            if (w && csr_addr_i == CSR_MCYCLE)       m_mcycle <= {m_mcycle[63:32], nv};
            else if (w && csr_addr_i == CSR_MCYCLEH) m_mcycle <= {nv, m_mcycle[31:0]};
            else                                     m_mcycle <= m_mcycle + 1;
            if (w && csr_addr_i == CSR_MINSTRET)       m_minstret <= {m_minstret[63:32], nv};
            else if (w && csr_addr_i == CSR_MINSTRETH) m_minstret <= {nv, m_minstret[31:0]};
            else if (retire_i)                         m_minstret <= m_minstret + 1;

            if (w && csr_addr_i == CSR_MSCRATCH) m_mscratch <= nv;
            if (w && csr_addr_i == CSR_MTVEC)    m_mtvec    <= nv & ~32'd3;
            if (w && owned && csr_addr_i == CSR_MEPC)    m_mepc   <= nv & ~32'd3;
            if (w && owned && csr_addr_i == CSR_MCAUSE)  m_mcause <= nv;
            if (w && owned && csr_addr_i == CSR_MTVAL)   m_mtval  <= nv;
            if (w && owned && csr_addr_i == CSR_MSTATUS) m_mstatus <= (nv & 32'h88) | 32'h1800;

            if (trap_valid_i) begin
                m_mepc    <= trap_pc_i & ~32'd3;
                m_mcause  <= trap_cause_i;
                m_mtval   <= trap_tval_i;
                // MPIE takes old MIE (bit 3 -> bit 7), MIE cleared
                m_mstatus <= 32'h1800 | (m_mstatus[3] ? 32'h80 : 32'h0);
            end else if (mret_i) begin
                m_mstatus <= 32'h1880 | (m_mstatus[7] ? 32'h8 : 32'h0);
            end
        end
    end

    // compare process: outputs are stable mid-cycle
    always @(negedge clk) begin
        if (m_valid) begin
            chk("cmp_rdata",   csr_rdata_o, m_read(csr_addr_i));
            chk("cmp_illegal", {31'd0, csr_illegal_o}, {31'd0, m_ill(csr_addr_i, csr_op_i)});
            chk("cmp_mtvec",   mtvec_o, m_mtvec);
            chk("cmp_mepc",    mepc_o, m_mepc);
            chk("cmp_mie",     {31'd0, mie_o}, {31'd0, m_mstatus[3]});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        csr_we_i = 0; trap_valid_i = 0; mret_i = 0; retire_i = 0;
        csr_op_i = CSR_READ; csr_addr_i = CSR_MCYCLE;
    endtask

    task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp);
        csr_addr_i = a; csr_op_i = CSR_READ; csr_we_i = 0;
        #1 chk(name, csr_rdata_o, exp);
    endtask

    task automatic wr(input string name, input logic [11:0] a, input csr_op_e op,
                      input logic [31:0] d, input logic [31:0] exp_old);
        csr_addr_i = a; csr_op_i = op; csr_wdata_i = d; csr_we_i = 1;
        #1 chk(name, csr_rdata_o, exp_old);
        step();
        csr_we_i = 0;
    endtask

    initial begin
        idle();
        rst_i = 1; step(); step(); rst_i = 0;

        // reset values
        rd("rst_mtvec", CSR_MTVEC, 32'h100);
        rd("rst_mepc", CSR_MEPC, 32'h0);
        rd("rst_mstatus", CSR_MSTATUS, 32'h1800);
        rd("rst_mhartid", CSR_MHARTID, 32'h0);
        chk("rst_illegal", {31'd0, csr_illegal_o}, 32'd0);
        chk("rst_mtvec_o", mtvec_o, 32'h100);
        chk("rst_mie_o", {31'd0, mie_o}, 32'd0);

        // write / set / clear sequence
        wr("scr_write", CSR_MSCRATCH, CSR_WRITE, 32'hA5A5_0000, 32'h0);
        wr("scr_set",   CSR_MSCRATCH, CSR_SET,   32'h0000_00FF, 32'hA5A5_0000);
        wr("scr_clear", CSR_MSCRATCH, CSR_CLEAR, 32'hA000_000F, 32'hA5A5_00FF);
        rd("scr_final", CSR_MSCRATCH, 32'h05A5_00F0);
        wr("mtvec_warl", CSR_MTVEC, CSR_WRITE, 32'h0000_0203, 32'h100);
        chk("mtvec_o_warl", mtvec_o, 32'h200);

        // trap entry then mret
        wr("mst_set", CSR_MSTATUS, CSR_SET, 32'h8, 32'h1800);
        rd("mst_mie", CSR_MSTATUS, 32'h1808);
        trap_valid_i = 1; trap_pc_i = 32'h1003; trap_cause_i = CAUSE_ILLEGAL_INSN;
        trap_tval_i = 32'hDEAD;
        step(); trap_valid_i = 0;
        rd("trap_mepc", CSR_MEPC, 32'h1000);
        rd("trap_mcause", CSR_MCAUSE, 32'h2);
        rd("trap_mtval", CSR_MTVAL, 32'hDEAD);
        rd("trap_mstatus", CSR_MSTATUS, 32'h1880);
        chk("trap_mie_o", {31'd0, mie_o}, 32'd0);
        mret_i = 1; step(); mret_i = 0;
        rd("mret_mstatus", CSR_MSTATUS, 32'h1888);
        chk("mret_mie_o", {31'd0, mie_o}, 32'd1);
        chk("mret_mepc_o", mepc_o, 32'h1000);

        // trap beats a same-edge write to mepc; retire still counts
        trap_valid_i = 1; trap_pc_i = 32'h2000; trap_cause_i = 32'd7; trap_tval_i = 32'h55;
        retire_i = 1;
        wr("coll_mepc", CSR_MEPC, CSR_WRITE, 32'h4444, 32'h1000);
        trap_valid_i = 0; retire_i = 0;
        rd("coll_mepc_rd", CSR_MEPC, 32'h2000);
        rd("coll_mst", CSR_MSTATUS, 32'h1880);
        rd("coll_minstret", CSR_MINSTRET, 32'h1);
        // trap + mret + mscratch write: mret dropped, mscratch commits
        trap_valid_i = 1; trap_pc_i = 32'h3000; trap_cause_i = CAUSE_ECALL_M;
        trap_tval_i = 32'h0; mret_i = 1;
        wr("coll_scr", CSR_MSCRATCH, CSR_WRITE, 32'h1234, 32'h05A5_00F0);
        trap_valid_i = 0; mret_i = 0;
        rd("coll_scr_rd", CSR_MSCRATCH, 32'h1234);
        rd("coll_mepc2", CSR_MEPC, 32'h3000);
        rd("coll_mst2", CSR_MSTATUS, 32'h1800);

        // counter wrap across halves
        wr("mcyc_wr", CSR_MCYCLE, CSR_WRITE, 32'hFFFF_FFFE, m_read(CSR_MCYCLE));
        step(); step(); step();
        rd("mcyc_lo", CSR_MCYCLE, 32'h1);
        rd("mcyc_hi", CSR_MCYCLEH, 32'h1);
        wr("minsth_wr", CSR_MINSTRETH, CSR_WRITE, 32'h7, 32'h0);
        rd("minsth_rd", CSR_MINSTRETH, 32'h7);
        rd("minst_lo_hold", CSR_MINSTRET, 32'h1);

        // read-only and unmapped
        csr_addr_i = CSR_MHARTID; csr_op_i = CSR_WRITE; csr_wdata_i = 32'h5; csr_we_i = 1;
        #1 chk("hart_illegal", {31'd0, csr_illegal_o}, 32'd1);
        step(); idle();
        rd("hart_rd", CSR_MHARTID, 32'h0);
        csr_addr_i = 12'h7C0; csr_op_i = CSR_WRITE; csr_wdata_i = 32'h9; csr_we_i = 1;
        #1 chk("unmap_rdata", csr_rdata_o, 32'h0);
        chk("unmap_illegal", {31'd0, csr_illegal_o}, 32'd1);
        step(); idle();

        // reset in the middle of a write burst
        wr("burst0", CSR_MSCRATCH, CSR_WRITE, 32'h1111, 32'h1234);
        rst_i = 1; trap_valid_i = 1; trap_pc_i = 32'h8000; retire_i = 1;
        csr_addr_i = CSR_MSCRATCH; csr_op_i = CSR_WRITE; csr_wdata_i = 32'h2222; csr_we_i = 1;
        step();
        rst_i = 0; idle();
        rd("rb_scr", CSR_MSCRATCH, 32'h0);
        rd("rb_mtvec", CSR_MTVEC, 32'h100);
        rd("rb_mepc", CSR_MEPC, 32'h0);
        rd("rb_mcause", CSR_MCAUSE, 32'h0);
        rd("rb_mstatus", CSR_MSTATUS, 32'h1800);
        rd("rb_mcycle", CSR_MCYCLE, 32'h0);
        rd("rb_minsth", CSR_MINSTRETH, 32'h0);
        retire_i = 1; step(); step(); retire_i = 0;
        rd("rb_minst", CSR_MINSTRET, 32'h2);
        idle(); step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
